// File: rtl/lc3_pkg.sv
`default_nettype none
// ============================================================================
// Module   : lc3_pkg
// Brief    : Shared widths, NZP encodings and register-index type for LC-3.
// Revision : 1.0 - initial release
// ============================================================================
package lc3_pkg;

  localparam int WORD_W   = 16;
  localparam int REG_AW   = 3;
  localparam int NUM_REGS = 8;

  localparam logic [2:0] NZP_N   = 3'b100;
  localparam logic [2:0] NZP_Z   = 3'b010;
  localparam logic [2:0] NZP_P   = 3'b001;
  localparam logic [2:0] NZP_RST = NZP_Z;

  typedef logic [REG_AW-1:0] reg_idx_t;

endpackage
`default_nettype wire

// File: rtl/lc3_nzp_gen.sv
`default_nettype none
// ============================================================================
// Module   : lc3_nzp_gen
// Brief    : Combinational one-hot {N,Z,P} classification of a signed word.
// Revision : 1.0 - initial release
// ============================================================================
module lc3_nzp_gen
  import lc3_pkg::*;
#(
  parameter int WIDTH = WORD_W
) (
  input  logic [WIDTH-1:0] value,
  output logic [2:0]       nzp
);

  always_comb begin
    nzp = NZP_P;
    if (value[WIDTH-1])
      nzp = NZP_N;
    else if (value == '0)
      nzp = NZP_Z;
  end

endmodule
`default_nettype wire

// File: rtl/lc3_regbank_wr.sv
`default_nettype none
// ============================================================================
// Module   : lc3_regbank_wr
// Brief    : LC-3 register file write side: 8 GPRs, NZP codes, busy
//            scoreboard. Define LC3_WR_BYPASS_EN for same-cycle write bypass.
// Revision : 1.0 - initial release
// ============================================================================
module lc3_regbank_wr
  import lc3_pkg::*;
#(
  parameter int WIDTH = WORD_W,
  parameter int NREG  = NUM_REGS
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             WE,
  input  reg_idx_t         DR,
  input  logic [WIDTH-1:0] D_IN,
  input  logic             LD_CC,
  input  logic             ISSUE_V,
  input  reg_idx_t         ISSUE_DR,
  output logic [WIDTH-1:0] Q0,
  output logic [WIDTH-1:0] Q1,
  output logic [WIDTH-1:0] Q2,
  output logic [WIDTH-1:0] Q3,
  output logic [WIDTH-1:0] Q4,
  output logic [WIDTH-1:0] Q5,
  output logic [WIDTH-1:0] Q6,
  output logic [WIDTH-1:0] Q7,
  output logic [2:0]       NZP,
  output logic [NREG-1:0]  BUSY
);

  logic [WIDTH-1:0] r_regs [NREG];
  logic [2:0]       r_nzp;
  logic [NREG-1:0]  r_busy;

  logic [2:0]       w_nzp;
  logic [NREG-1:0]  w_set;
  logic [NREG-1:0]  w_clr;
  logic [NREG-1:0]  w_busy_next;
  logic [WIDTH-1:0] w_q [NREG];

  lc3_nzp_gen #(
    .WIDTH (WIDTH)
  ) u_nzp_gen (
    .value (D_IN),
    .nzp   (w_nzp)
  );

  // Issue beats write-back on the same register: the new write is still owed.
  generate
    for (genvar i = 0; i < NREG; i++) begin : g_busy
      assign w_set[i]       = ISSUE_V && (ISSUE_DR == reg_idx_t'(i));
      assign w_clr[i]       = WE && (DR == reg_idx_t'(i));
      assign w_busy_next[i] = w_set[i] ? 1'b1 : (w_clr[i] ? 1'b0 : r_busy[i]);
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
      r_nzp  <= NZP_RST;
      r_busy <= '0;
    end else begin
      if (WE) begin
        r_regs[DR] <= D_IN;
      end
      if (WE && LD_CC) begin
        r_nzp <= w_nzp;
      end
      r_busy <= w_busy_next;
    end
  end

  generate
    for (genvar i = 0; i < NREG; i++) begin : g_q
`ifdef LC3_WR_BYPASS_EN
      assign w_q[i] = (WE && (DR == reg_idx_t'(i))) ? D_IN : r_regs[i];
`else
      assign w_q[i] = r_regs[i];
`endif
    end
  endgenerate

  assign Q0   = w_q[0];
  assign Q1   = w_q[1];
  assign Q2   = w_q[2];
  assign Q3   = w_q[3];
  assign Q4   = w_q[4];
  assign Q5   = w_q[5];
  assign Q6   = w_q[6];
  assign Q7   = w_q[7];
  assign NZP  = r_nzp;
  assign BUSY = r_busy;

endmodule
`default_nettype wire
